// File: rtl/mem_bus_decoder.sv
//----------------------------------------------------------------------------
// mem_bus_decoder
//
// Sits behind the merged CPU memory port and routes each request to either
// the on-chip RAM or the peripheral region, based on the request address.
// Every request finishes with a single-cycle bus_ready_o pulse. Unmapped
// addresses, requests that assert read and write together, and slaves that
// never answer all finish with bus_err_o set, so the CPU never stalls forever.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   bus_rd_i / bus_wr_i       merged-bus request strobes (held until ready)
//   bus_addr_i                byte address
//   bus_data_i                write data
//   bus_byte_select_i         byte lane enables
//   bus_ready_o               one-cycle completion pulse
//   bus_data_o                read data, valid with bus_ready_o
//   bus_err_o                 error flag, valid with bus_ready_o
//   ram_*                     RAM slave port (offset address, strobes, lanes)
//   periph_*                  peripheral slave port, same contract as RAM
//
// All outputs are registered. The FSM has three states: IDLE samples a
// request, ACCESS holds the slave strobe until ready or timeout, and RESP
// presents the completion pulse for exactly one cycle.
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_bus_decoder #(
  parameter logic [31:0] RAM_BASE         = 32'h0000_0000,
  parameter int unsigned RAM_SIZE_LOG2    = 16,
  parameter logic [31:0] PERIPH_BASE      = 32'h1000_0000,
  parameter int unsigned PERIPH_SIZE_LOG2 = 12,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        bus_rd_i,
  input  logic        bus_wr_i,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_data_i,
  input  logic [3:0]  bus_byte_select_i,
  output logic        bus_ready_o,
  output logic [31:0] bus_data_o,
  output logic        bus_err_o,

  output logic        ram_rd_o,
  output logic        ram_wr_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic [3:0]  ram_byte_select_o,
  input  logic        ram_ready_i,
  input  logic [31:0] ram_data_i,

  output logic        periph_rd_o,
  output logic        periph_wr_o,
  output logic [31:0] periph_addr_o,
  output logic [31:0] periph_data_o,
  output logic [3:0]  periph_byte_select_o,
  input  logic        periph_ready_i,
  input  logic [31:0] periph_data_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Offset masks; computed in 64 bits so a full 32-bit region still works.
  localparam logic [31:0] RAM_MASK    = 32'((64'd1 << RAM_SIZE_LOG2) - 64'd1);
  localparam logic [31:0] PERIPH_MASK = 32'((64'd1 << PERIPH_SIZE_LOG2) - 64'd1);

  // Last counter value of the wait window; the access gives up after the
  // strobe has been high for TIMEOUT_CYCLES cycles.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] timeout_cnt;
  logic        sel_ram;
  logic        is_write;

  logic        req;
  logic        req_illegal;
  logic        ram_hit;
  logic        periph_hit;
  logic        sel_ready;
  logic [31:0] sel_rdata;

  // Address decode and selection of the active slave's response. Regions are
  // aligned, so a region match is a compare of the bits above the offset, and
  // the offset is simply the low bits of the address.
  always_comb begin
    req         = bus_rd_i | bus_wr_i;
    req_illegal = bus_rd_i & bus_wr_i;
    ram_hit     = (bus_addr_i & ~RAM_MASK) == (RAM_BASE & ~RAM_MASK);
    periph_hit  = (bus_addr_i & ~PERIPH_MASK) == (PERIPH_BASE & ~PERIPH_MASK);
    sel_ready   = sel_ram ? ram_ready_i : periph_ready_i;
    sel_rdata   = sel_ram ? ram_data_i  : periph_data_i;
  end

  // Main FSM. Only the selected slave's fields are reloaded when a request is
  // accepted; the other slave keeps its previous (inert) field values while
  // its strobes stay low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state                <= ST_IDLE;
      timeout_cnt          <= '0;
      sel_ram              <= 1'b0;
      is_write             <= 1'b0;
      bus_ready_o          <= 1'b0;
      bus_data_o           <= '0;
      bus_err_o            <= 1'b0;
      ram_rd_o             <= 1'b0;
      ram_wr_o             <= 1'b0;
      ram_addr_o           <= '0;
      ram_data_o           <= '0;
      ram_byte_select_o    <= '0;
      periph_rd_o          <= 1'b0;
      periph_wr_o          <= 1'b0;
      periph_addr_o        <= '0;
      periph_data_o        <= '0;
      periph_byte_select_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus_ready_o <= 1'b0;
          bus_data_o  <= '0;
          bus_err_o   <= 1'b0;
          timeout_cnt <= '0;
          if (req) begin
            if (req_illegal || !(ram_hit || periph_hit)) begin
              // Complete immediately with an error; no slave sees the access.
              bus_ready_o <= 1'b1;
              bus_err_o   <= 1'b1;
              state       <= ST_RESP;
            end else if (ram_hit) begin
              sel_ram           <= 1'b1;
              is_write          <= bus_wr_i;
              ram_rd_o          <= bus_rd_i;
              ram_wr_o          <= bus_wr_i;
              ram_addr_o        <= bus_addr_i & RAM_MASK;
              ram_data_o        <= bus_data_i;
              ram_byte_select_o <= bus_byte_select_i;
              state             <= ST_ACCESS;
            end else begin
              sel_ram              <= 1'b0;
              is_write             <= bus_wr_i;
              periph_rd_o          <= bus_rd_i;
              periph_wr_o          <= bus_wr_i;
              periph_addr_o        <= bus_addr_i & PERIPH_MASK;
              periph_data_o        <= bus_data_i;
              periph_byte_select_o <= bus_byte_select_i;
              state                <= ST_ACCESS;
            end
          end
        end

        ST_ACCESS: begin
          // A ready in the last window cycle still counts as a normal finish.
          if (sel_ready) begin
            ram_rd_o    <= 1'b0;
            ram_wr_o    <= 1'b0;
            periph_rd_o <= 1'b0;
            periph_wr_o <= 1'b0;
            bus_ready_o <= 1'b1;
            bus_err_o   <= 1'b0;
            bus_data_o  <= is_write ? 32'h0 : sel_rdata;
            state       <= ST_RESP;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            ram_rd_o    <= 1'b0;
            ram_wr_o    <= 1'b0;
            periph_rd_o <= 1'b0;
            periph_wr_o <= 1'b0;
            bus_ready_o <= 1'b1;
            bus_err_o   <= 1'b1;
            bus_data_o  <= '0;
            state       <= ST_RESP;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end

        ST_RESP: begin
          // Request inputs are deliberately ignored here: the CPU is still
          // holding the request that just completed.
          bus_ready_o <= 1'b0;
          bus_data_o  <= '0;
          bus_err_o   <= 1'b0;
          timeout_cnt <= '0;
          state       <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_decoder.sv
//----------------------------------------------------------------------------
// tb_mem_bus_decoder
//
// Directed bench for mem_bus_decoder with hand-computed expectations.
// Cycle numbering in the comments: cycle 0 is the cycle in which a request
// is first presented; inputs are driven and outputs sampled 1 ns after each
// rising edge. The decoder is built with TIMEOUT_CYCLES=8.
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_bus_decoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        bus_rd_i;
  logic        bus_wr_i;
  logic [31:0] bus_addr_i;
  logic [31:0] bus_data_i;
  logic [3:0]  bus_byte_select_i;
  logic        bus_ready_o;
  logic [31:0] bus_data_o;
  logic        bus_err_o;
  logic        ram_rd_o;
  logic        ram_wr_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [3:0]  ram_byte_select_o;
  logic        ram_ready_i;
  logic [31:0] ram_data_i;
  logic        periph_rd_o;
  logic        periph_wr_o;
  logic [31:0] periph_addr_o;
  logic [31:0] periph_data_o;
  logic [3:0]  periph_byte_select_o;
  logic        periph_ready_i;
  logic [31:0] periph_data_i;

  int total_checks = 0;
  int bad_checks   = 0;
  logic ram_strobe_seen;

  mem_bus_decoder #(
    .RAM_BASE         (32'h0000_0000),
    .RAM_SIZE_LOG2    (16),
    .PERIPH_BASE      (32'h1000_0000),
    .PERIPH_SIZE_LOG2 (12),
    .TIMEOUT_CYCLES   (8)
  ) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .bus_rd_i             (bus_rd_i),
    .bus_wr_i             (bus_wr_i),
    .bus_addr_i           (bus_addr_i),
    .bus_data_i           (bus_data_i),
    .bus_byte_select_i    (bus_byte_select_i),
    .bus_ready_o          (bus_ready_o),
    .bus_data_o           (bus_data_o),
    .bus_err_o            (bus_err_o),
    .ram_rd_o             (ram_rd_o),
    .ram_wr_o             (ram_wr_o),
    .ram_addr_o           (ram_addr_o),
    .ram_data_o           (ram_data_o),
    .ram_byte_select_o    (ram_byte_select_o),
    .ram_ready_i          (ram_ready_i),
    .ram_data_i           (ram_data_i),
    .periph_rd_o          (periph_rd_o),
    .periph_wr_o          (periph_wr_o),
    .periph_addr_o        (periph_addr_o),
    .periph_data_o        (periph_data_o),
    .periph_byte_select_o (periph_byte_select_o),
    .periph_ready_i       (periph_ready_i),
    .periph_data_i        (periph_data_i)
  );

  // 100 MHz clock
  always #5 clk_i = ~clk_i;

  // Sticky flag: did any RAM strobe go high since it was last cleared?
  always @(posedge clk_i) begin
    if (ram_rd_o || ram_wr_o) ram_strobe_seen <= 1'b1;
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] bs);
    bus_rd_i          = rd;
    bus_wr_i          = wr;
    bus_addr_i        = addr;
    bus_data_i        = data;
    bus_byte_select_i = bs;
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i          = 1'b1;
    ram_ready_i    = 1'b0;
    ram_data_i     = 32'h0;
    periph_ready_i = 1'b0;
    periph_data_i  = 32'h0;
    ram_strobe_seen = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state
    nextCycle();
    nextCycle();
    checkOutput("reset_bus", {29'h0, bus_ready_o, bus_err_o, |bus_data_o}, 32'h0);
    checkOutput("reset_strobes", {28'h0, ram_rd_o, ram_wr_o, periph_rd_o, periph_wr_o}, 32'h0);
    checkOutput("reset_ram_addr", ram_addr_o, 32'h0);
    rst_i = 1'b0;
    nextCycle();

    // 1. RAM read at 0x10, ready two cycles after the strobe rises
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);     // cycle 0
    nextCycle();                                               // cycle 1
    checkOutput("t1_ram_rd", {31'h0, ram_rd_o}, 32'h1);
    checkOutput("t1_ram_addr", ram_addr_o, 32'h10);
    checkOutput("t1_periph_rd", {31'h0, periph_rd_o}, 32'h0);
    nextCycle();                                               // cycle 2
    checkOutput("t1_wait_ready", {30'h0, ram_rd_o, bus_ready_o}, 32'h2);
    nextCycle();                                               // cycle 3
    ram_ready_i = 1'b1;
    ram_data_i  = 32'hCAFE_F00D;
    nextCycle();                                               // cycle 4
    ram_ready_i = 1'b0;
    checkOutput("t1_ready", {31'h0, bus_ready_o}, 32'h1);
    checkOutput("t1_data", bus_data_o, 32'hCAFE_F00D);
    checkOutput("t1_err", {31'h0, bus_err_o}, 32'h0);
    checkOutput("t1_ram_rd_drop", {31'h0, ram_rd_o}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nextCycle();                                               // cycle 5
    checkOutput("t1_ready_pulse", {31'h0, bus_ready_o}, 32'h0);
    checkOutput("t1_data_clear", bus_data_o, 32'h0);

    // 2. Peripheral write, slave answers in the first strobe cycle
    ram_strobe_seen = 1'b0;
    periph_data_i   = 32'h5555_AAAA;
    applyStimulus(1'b0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0011);
    nextCycle();                                               // cycle 1
    checkOutput("t2_periph_wr", {30'h0, periph_wr_o, periph_rd_o}, 32'h2);
    checkOutput("t2_periph_addr", periph_addr_o, 32'h4);
    checkOutput("t2_periph_data", periph_data_o, 32'hDEAD_BEEF);
    checkOutput("t2_periph_bs", {28'h0, periph_byte_select_o}, 32'h3);
    periph_ready_i = 1'b1;
    nextCycle();                                               // cycle 2
    periph_ready_i = 1'b0;
    checkOutput("t2_ready", {30'h0, bus_ready_o, bus_err_o}, 32'h2);
    checkOutput("t2_write_data_zero", bus_data_o, 32'h0);
    checkOutput("t2_periph_wr_drop", {31'h0, periph_wr_o}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nextCycle();
    checkOutput("t2_ram_never", {31'h0, ram_strobe_seen}, 32'h0);

    // 3. Unmapped read completes with error in cycle 1
    applyStimulus(1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'hF);
    nextCycle();                                               // cycle 1
    checkOutput("t3_ready_err", {30'h0, bus_ready_o, bus_err_o}, 32'h3);
    checkOutput("t3_data", bus_data_o, 32'h0);
    checkOutput("t3_strobes", {28'h0, ram_rd_o, ram_wr_o, periph_rd_o, periph_wr_o}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nextCycle();                                               // cycle 2
    checkOutput("t3_idle", {30'h0, bus_ready_o, bus_err_o}, 32'h0);

    // 4. RAM read that never gets ready: 8 strobe cycles, then error
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    for (int i = 1; i <= 8; i++) begin
      nextCycle();                                             // cycles 1..8
      checkOutput($sformatf("t4_strobe_c%0d", i), {30'h0, ram_rd_o, bus_ready_o}, 32'h2);
    end
    nextCycle();                                               // cycle 9
    checkOutput("t4_timeout", {29'h0, ram_rd_o, bus_ready_o, bus_err_o}, 32'h3);
    checkOutput("t4_data", bus_data_o, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    ram_ready_i = 1'b1;                                        // late ready
    ram_data_i  = 32'hBAD0_BAD0;
    nextCycle();                                               // cycle 10
    checkOutput("t4_late_ready1", {30'h0, bus_ready_o, ram_rd_o}, 32'h0);
    nextCycle();                                               // cycle 11
    checkOutput("t4_late_ready2", {30'h0, bus_ready_o, ram_rd_o}, 32'h0);
    ram_ready_i = 1'b0;

    // 5. Reset in the middle of a RAM access, then a normal peripheral read
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
    nextCycle();                                               // cycle 1
    checkOutput("t5_ram_rd", {31'h0, ram_rd_o}, 32'h1);
    nextCycle();                                               // cycle 2
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nextCycle();                                               // cycle 3
    rst_i = 1'b0;
    checkOutput("t5_after_reset", {29'h0, ram_rd_o, bus_ready_o, bus_err_o}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h1000_0008, 32'h0, 4'hF);
    nextCycle();                                               // cycle 4
    checkOutput("t5_periph_rd", {30'h0, periph_rd_o, ram_rd_o}, 32'h2);
    checkOutput("t5_periph_addr", periph_addr_o, 32'h8);
    periph_ready_i = 1'b1;
    periph_data_i  = 32'h1234_5678;
    ram_ready_i    = 1'b1;                                     // non-selected slave
    ram_data_i     = 32'hFFFF_0000;
    nextCycle();                                               // cycle 5
    periph_ready_i = 1'b0;
    ram_ready_i    = 1'b0;
    checkOutput("t5_ready", {30'h0, bus_ready_o, bus_err_o}, 32'h2);
    checkOutput("t5_data", bus_data_o, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nextCycle();

    // 6a. Read and write together -> error response
    applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'h0, 4'hF);
    nextCycle();                                               // cycle 1
    checkOutput("t6_rdwr_err", {30'h0, bus_ready_o, bus_err_o}, 32'h3);
    checkOutput("t6_rdwr_strobes", {28'h0, ram_rd_o, ram_wr_o, periph_rd_o, periph_wr_o}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nextCycle();                                               // IDLE

    // 6b. Back-to-back RAM reads; the second request is held through RESP
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);     // cycle 0
    nextCycle();                                               // cycle 1
    checkOutput("t6_b1_addr", ram_addr_o, 32'h40);
    ram_ready_i = 1'b1;
    ram_data_i  = 32'h1111_1111;
    nextCycle();                                               // cycle 2 (RESP)
    ram_ready_i = 1'b0;
    checkOutput("t6_b1_ready", {30'h0, bus_ready_o, bus_err_o}, 32'h2);
    checkOutput("t6_b1_data", bus_data_o, 32'h1111_1111);
    applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'hF);
    nextCycle();                                               // cycle 3 (IDLE)
    checkOutput("t6_gap", {30'h0, bus_ready_o, ram_rd_o}, 32'h0);
    nextCycle();                                               // cycle 4
    checkOutput("t6_b2_rd", {31'h0, ram_rd_o}, 32'h1);
    checkOutput("t6_b2_addr", ram_addr_o, 32'h44);
    ram_ready_i = 1'b1;
    ram_data_i  = 32'h2222_2222;
    nextCycle();                                               // cycle 5
    ram_ready_i = 1'b0;
    checkOutput("t6_b2_ready", {30'h0, bus_ready_o, bus_err_o}, 32'h2);
    checkOutput("t6_b2_data", bus_data_o, 32'h2222_2222);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nextCycle();
    checkOutput("t6_end_idle", {30'h0, bus_ready_o, ram_rd_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
